// File: rtl/output_pulse_driver_if.sv
// Request/status bundle for output_pulse_driver: trigger, width and hold in;
// pulse pin, status flags and queue depth out.
interface output_pulse_driver_if #(
    parameter int PEND_W = 4
);
    logic              trig;
    logic [24:0]       width;
    logic              hold;
    logic              out_n;
    logic              out_state;
    logic              busy;
    logic              done;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    modport master (
        output trig, width, hold,
        input  out_n, out_state, busy, done, pend_cnt, overflow
    );

    modport slave (
        input  trig, width, hold,
        output out_n, out_state, busy, done, pend_cnt, overflow
    );
endinterface

// File: rtl/output_pulse_driver.sv
// Active-low pulse driver with a forced idle gap between pulses and a saturating trigger queue.
// Define OUTPUT_REPEAT_EN to auto-repeat pulses while hold stays high.
module output_pulse_driver #(
    parameter int GAP    = 64,
    parameter int PEND_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output_pulse_driver_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    localparam logic [15:0]       GAP_LAST = 16'(GAP - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [24:0]       wcnt;
    logic [24:0]       wcnt_nx;
    logic [15:0]       gcnt;
    logic [15:0]       gcnt_nx;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_nx;
    logic              pulse_q;
    logic              pulse_nx;
    logic              out_n_q;
    logic              busy_q;
    logic              done_q;
    logic              done_nx;
    logic              ovf_q;
    logic              ovf_nx;
    logic              capture;
    logic              repeat_req;
    logic [PEND_W:0]   queued;

    // Returns {dropped, new_count}; a full queue drops the trigger rather than wrapping.
    function automatic logic [PEND_W:0] queue_trig(input logic t, input logic [PEND_W-1:0] cnt);
        if (!t) begin
            return {1'b0, cnt};
        end else if (cnt == PEND_MAX) begin
            return {1'b1, cnt};
        end else begin
            return {1'b0, cnt + PEND_ONE};
        end
    endfunction

`ifdef OUTPUT_REPEAT_EN
    assign repeat_req = bus.hold;
`else
    logic unused_hold;
    assign repeat_req  = 1'b0;
    assign unused_hold = bus.hold;
`endif

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        gcnt_nx  = gcnt;
        pend_nx  = pend;
        pulse_nx = pulse_q;
        done_nx  = 1'b0;
        ovf_nx   = 1'b0;
        capture  = 1'b0;
        queued   = queue_trig(bus.trig, pend);

        case (state)
            S_IDLE: begin
                capture = bus.trig;
            end

            S_ACTIVE: begin
                pend_nx = queued[PEND_W-1:0];
                ovf_nx  = queued[PEND_W];
                if (wcnt == 25'd0) begin
                    state_nx = S_GAP;
                    pulse_nx = 1'b0;
                    gcnt_nx  = GAP_LAST;
                end else begin
                    wcnt_nx = wcnt - 25'd1;
                    done_nx = (wcnt == 25'd1);
                end
            end

            S_GAP: begin
                if (gcnt != 16'd0) begin
                    gcnt_nx = gcnt - 16'd1;
                    pend_nx = queued[PEND_W-1:0];
                    ovf_nx  = queued[PEND_W];
                // A trigger on the final gap edge is queued and consumed at once: queue depth is unchanged.
                end else if (bus.trig) begin
                    capture = 1'b1;
                end else if (pend != '0) begin
                    pend_nx = pend - PEND_ONE;
                    capture = 1'b1;
                end else if (repeat_req) begin
                    capture = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
                pulse_nx = 1'b0;
            end
        endcase

        if (capture) begin
            state_nx = S_ACTIVE;
            pulse_nx = 1'b1;
            wcnt_nx  = (bus.width == 25'd0) ? 25'd0 : bus.width - 25'd1;
            done_nx  = (bus.width <= 25'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            gcnt    <= '0;
            pend    <= '0;
            pulse_q <= 1'b0;
            out_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            wcnt    <= wcnt_nx;
            gcnt    <= gcnt_nx;
            pend    <= pend_nx;
            pulse_q <= pulse_nx;
            out_n_q <= ~pulse_nx;
            busy_q  <= (state_nx != S_IDLE);
            done_q  <= done_nx;
            ovf_q   <= ovf_nx;
        end
    end

    assign bus.out_n     = out_n_q;
    assign bus.out_state = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pend_cnt  = pend;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_output_pulse_driver.sv
// Bench for output_pulse_driver: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a pulse-schedule reference model.
module tb_output_pulse_driver;
    localparam int GAP    = 64;
    localparam int PEND_W = 4;
    localparam int PMAX   = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    output_pulse_driver_if #(.PEND_W(PEND_W)) bus ();

    output_pulse_driver #(.GAP(GAP), .PEND_W(PEND_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a pulse is a start cycle plus a length; everything else follows from arithmetic.
    longint m_e    = 0;
    longint m_s    = -1000000;
    longint m_l    = 1;
    int     m_pend = 0;
    bit     m_ovf  = 1'b0;

    function automatic int cyc();
        return int'(m_e) - 1;
    endfunction

    task automatic start_pulse();
        m_s = m_e;
        m_l = (bus.width == 25'd0) ? 64'd1 : longint'(bus.width);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e    = 0;
            m_s    = -1000000;
            m_l    = 1;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (m_e >= m_s + m_l + GAP) begin
                if (bus.trig) begin
                    start_pulse();
                end else if (m_pend > 0) begin
                    m_pend--;
                    start_pulse();
                end
`ifdef OUTPUT_REPEAT_EN
                else if (bus.hold && (m_e == m_s + m_l + GAP)) begin
                    start_pulse();
                end
`endif
            end else if (bus.trig) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end
            m_e++;
        end
    end

    function automatic logic [8:0] model_vec();
        longint c;
        logic   os;
        logic   bz;
        logic   dn;
        c  = m_e - 1;
        os = (c >= m_s) && (c < m_s + m_l);
        bz = (c >= m_s) && (c < m_s + m_l + GAP);
        dn = (c == m_s + m_l - 1);
        return {~os, os, bz, dn, 4'(m_pend), m_ovf};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {bus.out_n, bus.out_state, bus.busy, bus.done, bus.pend_cnt, bus.overflow};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc(), act, exp);
    endtask

    always @(negedge clk) chk("model", 32'(dut_vec()), 32'(model_vec()));

    task automatic next_cycle();
        @(negedge clk);
        bus.trig = 1'b0;
    endtask

    int   ovf_seen;
    int   pulses;
    int   pend_peak;
    logic prev_os;

    task automatic obs_reset();
        ovf_seen  = 0;
        pulses    = 0;
        pend_peak = 0;
        prev_os   = bus.out_state;
    endtask

    task automatic step_obs();
        next_cycle();
        if (bus.overflow) ovf_seen++;
        if (bus.out_state && !prev_os) pulses++;
        prev_os = bus.out_state;
        if (int'(bus.pend_cnt) > pend_peak) pend_peak = int'(bus.pend_cnt);
    endtask

    typedef struct {
        int          cyc;
        logic        trig;
        logic [24:0] width;
        logic        e_out_n;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_pend;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int done_seen;

        // Each row: at this cycle expect these outputs, then drive these inputs for the cycle.
        vec[0]  = '{10,  1'b1, 25'd5, 1'b1, 1'b0, 1'b0, 4'd0};
        vec[1]  = '{11,  1'b0, 25'd5, 1'b0, 1'b1, 1'b0, 4'd0};
        vec[2]  = '{14,  1'b0, 25'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        vec[3]  = '{15,  1'b0, 25'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        vec[4]  = '{16,  1'b0, 25'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vec[5]  = '{79,  1'b0, 25'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vec[6]  = '{80,  1'b1, 25'd0, 1'b1, 1'b0, 1'b0, 4'd0};
        vec[7]  = '{81,  1'b0, 25'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        vec[8]  = '{82,  1'b0, 25'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vec[9]  = '{145, 1'b0, 25'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vec[10] = '{146, 1'b0, 25'd0, 1'b1, 1'b0, 1'b0, 4'd0};

        bus.trig  = 1'b0;
        bus.width = 25'd0;
        bus.hold  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_n", 32'(bus.out_n), 32'd1);
        chk("rst_out_state", 32'(bus.out_state), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            while (cyc() < vec[i].cyc) next_cycle();
            chk($sformatf("vec%0d", i),
                32'({bus.out_n, bus.busy, bus.done, bus.pend_cnt}),
                32'({vec[i].e_out_n, vec[i].e_busy, vec[i].e_done, vec[i].e_pend}));
            bus.trig  = vec[i].trig;
            bus.width = vec[i].width;
        end

        // 21 consecutive trigger cycles: one starts the pulse, 15 queue, 5 are dropped.
        next_cycle();
        obs_reset();
        bus.width = 25'd30;
        for (int k = 0; k < 21; k++) begin
            bus.trig = 1'b1;
            step_obs();
        end
        for (int k = 0; k < 1600; k++) step_obs();
        chk("ovf_count", 32'(ovf_seen), 32'd5);
        chk("pend_peak", 32'(pend_peak), 32'd15);
        chk("pulse_count", 32'(pulses), 32'd16);
        chk("burst_drained", 32'(bus.busy), 32'd0);

        // Trigger on the last gap cycle while three are queued.
        bus.width = 25'd2;
        a = cyc();
        for (int k = 0; k < 4; k++) begin
            bus.trig = 1'b1;
            next_cycle();
        end
        while (cyc() < a + 66) next_cycle();
        chk("lastgap_pend_before", 32'(bus.pend_cnt), 32'd3);
        chk("lastgap_out_before", 32'(bus.out_state), 32'd0);
        bus.trig = 1'b1;
        next_cycle();
        chk("lastgap_pend_after", 32'(bus.pend_cnt), 32'd3);
        chk("lastgap_restart", 32'(bus.out_state), 32'd1);
        repeat (400) next_cycle();
        chk("queue3_drained", 32'(bus.busy), 32'd0);

        // Trigger on the last gap cycle with an empty queue: back-to-back pulse.
        bus.width = 25'd1;
        a = cyc();
        bus.trig = 1'b1;
        next_cycle();
        while (cyc() < a + 65) next_cycle();
        chk("b2b_gap_busy", 32'(bus.busy), 32'd1);
        bus.trig = 1'b1;
        next_cycle();
        chk("b2b_restart", 32'({bus.out_state, bus.done, bus.pend_cnt}), 32'({1'b1, 1'b1, 4'd0}));
        repeat (100) next_cycle();

        // Asynchronous reset in the middle of a long pulse with a non-empty queue.
        bus.width = 25'd100;
        for (int k = 0; k < 3; k++) begin
            bus.trig = 1'b1;
            next_cycle();
        end
        chk("midpulse_low", 32'({bus.out_n, bus.pend_cnt}), 32'({1'b0, 4'd2}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_n", 32'(bus.out_n), 32'd1);
        chk("async_state", 32'({bus.out_state, bus.busy, bus.pend_cnt}), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (bus.done) done_seen++;
        end
        chk("rst_no_done", 32'(done_seen), 32'd0);

        // Trigger on the very first edge after reset release is honoured.
        bus.width = 25'd3;
        bus.trig  = 1'b1;
        rst_n     = 1'b1;
        next_cycle();
        chk("first_edge_trig", 32'({bus.out_state, bus.busy, bus.done}), 32'({1'b1, 1'b1, 1'b0}));
        repeat (100) next_cycle();

        // Hold-driven repeat: four pulses in the window when enabled, one otherwise.
        bus.width = 25'd10;
        bus.hold  = 1'b1;
        obs_reset();
        bus.trig = 1'b1;
        for (int k = 0; k < 250; k++) step_obs();
        bus.hold = 1'b0;
`ifdef OUTPUT_REPEAT_EN
        chk("repeat_pulses", 32'(pulses), 32'd4);
`else
        chk("repeat_pulses", 32'(pulses), 32'd1);
`endif
        repeat (150) next_cycle();
        chk("repeat_stopped", 32'(bus.busy), 32'd0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            bus.trig  = ($urandom_range(0, 9) == 0);
            bus.hold  = ($urandom_range(0, 1) == 1);
            bus.width = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 40)) : 25'($urandom_range(0, 4));
            next_cycle();
        end
        bus.hold = 1'b0;
        repeat (1800) next_cycle();
        chk("random_drained", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
